// File: rtl/sysregs_pkg.sv
// Shared constants for the system register file: register offsets,
// lock FSM state encoding and the default unlock key bytes.
package sysregs_pkg;

  // Register offsets decoded from addr[3:0]; CTRL occupies 0..NUM_CTRL-1.
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_STICKY  = 4'h9;
  localparam logic [3:0] OFF_IRQMASK = 4'hA;
  localparam logic [3:0] OFF_KEY     = 4'hC;
  localparam logic [3:0] OFF_VIS_ON  = 4'hE;
  localparam logic [3:0] OFF_VIS_OFF = 4'hF;

  // Default two-byte unlock sequence written to OFF_KEY.
  localparam logic [7:0] DEF_KEY0 = 8'hA5;
  localparam logic [7:0] DEF_KEY1 = 8'h5A;

  // Lock FSM states.
  typedef enum logic [1:0] {
    LOCK_LOCKED   = 2'd0,
    LOCK_KEY_WAIT = 2'd1,
    LOCK_UNLOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/reg_lock_fsm.sv
// Write-protection FSM for the control registers. A two-byte key
// sequence unlocks the registers; an idle timeout, a key write while
// unlocked, or safe mode relocks them.
module reg_lock_fsm
  import sysregs_pkg::*;
#(
  parameter logic [7:0] KEY0         = DEF_KEY0,
  parameter logic [7:0] KEY1         = DEF_KEY1,
  parameter int         LOCK_TIMEOUT = 1024,
  localparam int        CW           = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          safe_mode_i,
  input  logic          key_wr_i,     // accepted write to the KEY offset
  input  logic [7:0]    key_data_i,
  input  logic          other_wr_i,   // accepted write to any other offset
  input  logic          ctrl_wr_i,    // accepted write to a CTRL offset
  output logic          unlocked_o,
  output lock_state_e   state_o,      // debug view of the FSM state
  output logic [CW-1:0] cnt_o         // debug view of the timeout counter
);

  localparam logic [CW-1:0] TO_VAL = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] ONE    = CW'(1);

  lock_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          unlocked_q;

  // Lock state, timeout counter and registered unlocked flag.
  // The counter reloads on entry to UNLOCKED and on every CTRL write,
  // and the FSM relocks on the edge where the count would hit zero, so
  // the registers stay open for exactly LOCK_TIMEOUT idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCK_LOCKED;
      cnt_q      <= '0;
      unlocked_q <= 1'b0;
    end else if (safe_mode_i) begin
      state_q    <= LOCK_LOCKED;
      cnt_q      <= '0;
      unlocked_q <= 1'b0;
    end else begin
      case (state_q)
        LOCK_LOCKED: begin
          if (key_wr_i && (key_data_i == KEY0)) begin
            state_q <= LOCK_KEY_WAIT;
          end
        end
        LOCK_KEY_WAIT: begin
          if (key_wr_i && (key_data_i == KEY1)) begin
            state_q    <= LOCK_UNLOCKED;
            cnt_q      <= TO_VAL;
            unlocked_q <= 1'b1;
          end else if (key_wr_i || other_wr_i) begin
            state_q <= LOCK_LOCKED;
          end
        end
        LOCK_UNLOCKED: begin
          if (key_wr_i) begin
            state_q    <= LOCK_LOCKED;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
          end else if (ctrl_wr_i) begin
            cnt_q <= TO_VAL;
          end else if (cnt_q <= ONE) begin
            state_q    <= LOCK_LOCKED;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: begin
          state_q    <= LOCK_LOCKED;
          cnt_q      <= '0;
          unlocked_q <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked_o = unlocked_q;
  assign state_o    = state_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/sys_regfile.sv
// System register file: write-protected control registers, live status,
// sticky W1C event capture with interrupt mask, a turbo button toggle
// and a visibility window over the whole register map.
//
// CPU port: a single-cycle strobe interface with no back-pressure.
// Every cycle with en=1 and we=1 is exactly one write of din to
// addr[3:0]; every cycle with en=1 and we=0 is a read whose data is
// presented combinationally on dout in the same cycle.
module sys_regfile
  import sysregs_pkg::*;
#(
  parameter int                      NUM_CTRL     = 4,
  parameter logic [NUM_CTRL*8-1:0]   CTRL_RST     = 32'h0000_0060,
  parameter logic [7:0]              KEY0         = DEF_KEY0,
  parameter logic [7:0]              KEY1         = DEF_KEY1,
  parameter int                      LOCK_TIMEOUT = 1024,
  parameter int                      TURBO_BIT    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic                  we,
  input  logic                  en,
  input  logic [7:0]            status_in,
  input  logic                  safe_mode,
  input  logic                  turbo_toggle,
  output logic [NUM_CTRL*8-1:0] ctrl_out,
  output logic                  regs_visible,
  output logic                  unlocked,
  output logic                  irq
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [NUM_CTRL*8-1:0] ctrl_q, ctrl_d;
  logic [7:0]            sticky_q, sticky_d;
  logic [7:0]            status_prev_q;
  logic [7:0]            irqmask_q;
  logic                  visible_q;
  logic                  irq_q;
  logic                  tgl_prev_q;

  logic [3:0]  off;
  logic        wr;
  logic        wr_acc;
  logic        is_ctrl;
  logic [7:0]  ctrl_rd;
  logic        key_wr;
  logic        other_wr;
  logic        ctrl_wr;
  logic        tgl_rise;
  logic [7:0]  sticky_clr;
  logic [7:0]  status_rise;

  lock_state_e lock_state;
  logic [CW-1:0] lock_cnt;
  logic        lock_unlocked;

  assign off = addr[3:0];
  assign wr  = en && we;

  // While the window is hidden only the VISIBLE-ON offset accepts writes.
  assign wr_acc = wr && (visible_q || (off == OFF_VIS_ON));

  // CTRL offset match and read mux; offsets at or above NUM_CTRL fall through.
  always_comb begin
    is_ctrl = 1'b0;
    ctrl_rd = 8'hFF;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (off == 4'(i)) begin
        is_ctrl = 1'b1;
        ctrl_rd = ctrl_q[i*8 +: 8];
      end
    end
  end

  assign key_wr   = wr_acc && (off == OFF_KEY) && !safe_mode;
  assign other_wr = wr_acc && (off != OFF_KEY) && !safe_mode;
  assign ctrl_wr  = wr_acc && is_ctrl && !safe_mode;

  reg_lock_fsm #(
    .KEY0         (KEY0),
    .KEY1         (KEY1),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock (
    .clk         (clk),
    .rst_n       (rst_n),
    .safe_mode_i (safe_mode),
    .key_wr_i    (key_wr),
    .key_data_i  (din),
    .other_wr_i  (other_wr),
    .ctrl_wr_i   (ctrl_wr),
    .unlocked_o  (lock_unlocked),
    .state_o     (lock_state),
    .cnt_o       (lock_cnt)
  );

  assign tgl_rise = turbo_toggle && !tgl_prev_q;

  // Next control value: button toggle first, an unlocked CPU write
  // overrides it, and safe mode overrides everything.
  always_comb begin
    ctrl_d = ctrl_q;
    if (tgl_rise) begin
      ctrl_d[TURBO_BIT] = ~ctrl_q[TURBO_BIT];
    end
    if (ctrl_wr && lock_unlocked) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (off == 4'(i)) begin
          ctrl_d[i*8 +: 8] = din;
        end
      end
    end
    if (safe_mode) begin
      ctrl_d = '0;
    end
  end

  // Control registers and the button edge-detector history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_RST;
      tgl_prev_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      tgl_prev_q <= turbo_toggle;
    end
  end

  assign status_rise = status_in & ~status_prev_q;
  assign sticky_clr  = (wr_acc && (off == OFF_STICKY) && !safe_mode) ? din : 8'h00;
  // A new event in the same cycle as its clear must not be lost.
  assign sticky_d    = (sticky_q & ~sticky_clr) | status_rise;

  // Sticky event capture; keeps running in safe mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q      <= 8'h00;
      status_prev_q <= 8'h00;
    end else begin
      sticky_q      <= sticky_d;
      status_prev_q <= status_in;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqmask_q <= 8'h00;
    end else if (safe_mode) begin
      irqmask_q <= 8'h00;
    end else if (wr_acc && (off == OFF_IRQMASK)) begin
      irqmask_q <= din;
    end
  end

  // Register-window visibility, independent of the lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visible_q <= 1'b1;
    end else if (safe_mode) begin
      visible_q <= 1'b1;
    end else if (wr && (off == OFF_VIS_ON)) begin
      visible_q <= 1'b1;
    end else if (wr_acc && (off == OFF_VIS_OFF)) begin
      visible_q <= 1'b0;
    end
  end

  // Interrupt request, one cycle behind the masked sticky bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(sticky_q & irqmask_q);
    end
  end

  // Combinational read mux; everything unmapped or hidden reads FF.
  always_comb begin
    dout = 8'hFF;
    if (en && visible_q) begin
      if (is_ctrl) begin
        dout = ctrl_rd;
      end else begin
        case (off)
          OFF_STATUS:  dout = status_in;
          OFF_STICKY:  dout = sticky_q;
          OFF_IRQMASK: dout = irqmask_q;
          OFF_KEY:     dout = 8'h00;
          default:     dout = 8'hFF;
        endcase
      end
    end
  end

  assign ctrl_out     = ctrl_q;
  assign regs_visible = visible_q;
  assign unlocked     = lock_unlocked;
  assign irq          = irq_q;

  // Upper address bits are decoded upstream; FSM debug views are for probing.
  logic unused_ok;
  assign unused_ok = ^{addr[15:4], lock_state, lock_cnt};

endmodule

// File: tb/tb_sys_regfile.sv
// Directed testbench for sys_regfile with hand-computed expectations.
module tb_sys_regfile;

  localparam int NUM_CTRL     = 4;
  localparam int LOCK_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        we;
  logic        en;
  logic [7:0]  status_in;
  logic        safe_mode;
  logic        turbo_toggle;
  logic [31:0] ctrl_out;
  logic        regs_visible;
  logic        unlocked;
  logic        irq;

  int tests;
  int fails;

  sys_regfile #(
    .NUM_CTRL     (NUM_CTRL),
    .CTRL_RST     (32'h0000_0060),
    .KEY0         (8'hA5),
    .KEY1         (8'h5A),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .TURBO_BIT    (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .din          (din),
    .dout         (dout),
    .we           (we),
    .en           (en),
    .status_in    (status_in),
    .safe_mode    (safe_mode),
    .turbo_toggle (turbo_toggle),
    .ctrl_out     (ctrl_out),
    .regs_visible (regs_visible),
    .unlocked     (unlocked),
    .irq          (irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver and check tasks; all inputs change on the falling edge.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [7:0] data);
    addr = {12'h000, off};
    din  = data;
    en   = 1'b1;
    we   = 1'b1;
    @(negedge clk);
    en   = 1'b0;
    we   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] off, input logic [7:0] exp);
    addr = {12'h000, off};
    en   = 1'b1;
    we   = 1'b0;
    #1;
    check(tag, {24'h0, dout}, {24'h0, exp});
    en   = 1'b0;
  endtask

  // Directed sequence
  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    addr         = 16'h0;
    din          = 8'h00;
    we           = 1'b0;
    en           = 1'b0;
    status_in    = 8'h00;
    safe_mode    = 1'b0;
    turbo_toggle = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_ctrl_out", ctrl_out, 32'h0000_0060);
    check("rst_unlocked", {31'h0, unlocked}, 32'h0);
    check("rst_visible", {31'h0, regs_visible}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    read_chk("rd_ctrl0_rst", 4'h0, 8'h60);
    read_chk("rd_ctrl3_rst", 4'h3, 8'h00);
    read_chk("rd_unmapped5", 4'h5, 8'hFF);
    read_chk("rd_key_zero", 4'hC, 8'h00);
    addr = 16'h0000;
    en   = 1'b0;
    #1;
    check("rd_en_low", {24'h0, dout}, 32'h0000_00FF);

    // Locked write ignored
    cpu_write(4'h0, 8'h00);
    check("locked_wr_ignored", {24'h0, ctrl_out[7:0]}, 32'h60);

    // Unlock, write, then idle timeout
    cpu_write(4'hC, 8'hA5);
    check("key0_not_yet_unlocked", {31'h0, unlocked}, 32'h0);
    cpu_write(4'hC, 8'h5A);
    check("unlock_seq", {31'h0, unlocked}, 32'h1);
    cpu_write(4'h0, 8'h00);
    check("unlocked_wr_ctrl0", {24'h0, ctrl_out[7:0]}, 32'h00);
    tick(LOCK_TIMEOUT - 1);
    check("timeout_not_yet", {31'h0, unlocked}, 32'h1);
    tick(1);
    check("timeout_relock", {31'h0, unlocked}, 32'h0);

    // Interrupted key sequence stays locked
    cpu_write(4'hC, 8'hA5);
    cpu_write(4'h9, 8'hFF);
    cpu_write(4'hC, 8'h5A);
    check("broken_seq_locked", {31'h0, unlocked}, 32'h0);

    // Sticky capture, irq latency, set-wins-over-clear
    cpu_write(4'hC, 8'hA5);
    cpu_write(4'hC, 8'h5A);
    cpu_write(4'hA, 8'h01);
    read_chk("rd_irqmask", 4'hA, 8'h01);
    status_in = 8'h01;
    tick(1);
    read_chk("sticky_set", 4'h9, 8'h01);
    check("irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_asserted", {31'h0, irq}, 32'h1);
    status_in = 8'h00;
    tick(1);
    status_in = 8'h01;
    cpu_write(4'h9, 8'h01);
    read_chk("sticky_set_wins", 4'h9, 8'h01);
    check("irq_held", {31'h0, irq}, 32'h1);
    cpu_write(4'h9, 8'h01);
    read_chk("sticky_w1c", 4'h9, 8'h00);
    check("irq_clear_lag", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    status_in = 8'h81;
    read_chk("rd_status_live", 4'h8, 8'h81);
    tick(2);
    read_chk("sticky_bit7", 4'h9, 8'h80);
    check("irq_masked_off", {31'h0, irq}, 32'h0);

    // Key write while unlocked relocks
    check("still_unlocked", {31'h0, unlocked}, 32'h1);
    cpu_write(4'hC, 8'h00);
    check("key_relock", {31'h0, unlocked}, 32'h0);

    // Turbo toggle while locked
    turbo_toggle = 1'b1;
    tick(1);
    turbo_toggle = 1'b0;
    check("turbo_0_to_1", {24'h0, ctrl_out[7:0]}, 32'h40);
    tick(1);
    turbo_toggle = 1'b1;
    tick(3);
    turbo_toggle = 1'b0;
    check("turbo_held_once", {24'h0, ctrl_out[7:0]}, 32'h00);
    tick(1);
    turbo_toggle = 1'b1;
    tick(1);
    turbo_toggle = 1'b0;
    check("turbo_again", {24'h0, ctrl_out[7:0]}, 32'h40);
    tick(1);

    // Coincident toggle and unlocked write: write wins
    cpu_write(4'hC, 8'hA5);
    cpu_write(4'hC, 8'h5A);
    check("unlock_2", {31'h0, unlocked}, 32'h1);
    turbo_toggle = 1'b1;
    cpu_write(4'h0, 8'h40);
    turbo_toggle = 1'b0;
    check("write_beats_toggle", {24'h0, ctrl_out[7:0]}, 32'h40);
    tick(1);

    // Visibility window
    cpu_write(4'hF, 8'h00);
    check("vis_off", {31'h0, regs_visible}, 32'h0);
    read_chk("rd_hidden", 4'h0, 8'hFF);
    cpu_write(4'h0, 8'h11);
    check("hidden_wr_ignored", {24'h0, ctrl_out[7:0]}, 32'h40);
    cpu_write(4'hE, 8'h00);
    check("vis_on", {31'h0, regs_visible}, 32'h1);
    read_chk("rd_visible_again", 4'h0, 8'h40);

    // Safe mode
    cpu_write(4'hF, 8'h00);
    safe_mode = 1'b1;
    status_in = 8'h83;
    tick(1);
    check("safe_ctrl_zero", ctrl_out, 32'h0);
    check("safe_visible", {31'h0, regs_visible}, 32'h1);
    check("safe_locked", {31'h0, unlocked}, 32'h0);
    read_chk("safe_sticky_capture", 4'h9, 8'h82);
    read_chk("safe_irqmask_zero", 4'hA, 8'h00);
    turbo_toggle = 1'b1;
    cpu_write(4'hC, 8'hA5);
    turbo_toggle = 1'b0;
    cpu_write(4'hC, 8'h5A);
    check("safe_ignores_keys", {31'h0, unlocked}, 32'h0);
    check("safe_ignores_toggle", ctrl_out, 32'h0);
    safe_mode = 1'b0;
    tick(1);
    check("release_ctrl", ctrl_out, 32'h0);
    check("release_locked", {31'h0, unlocked}, 32'h0);
    check("release_irq", {31'h0, irq}, 32'h0);

    // Reset in the middle of the unlock sequence
    status_in = 8'h00;
    cpu_write(4'hC, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_out, 32'h0000_0060);
    check("async_rst_visible", {31'h0, regs_visible}, 32'h1);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    cpu_write(4'hC, 8'h5A);
    check("rst_mid_seq_locked", {31'h0, unlocked}, 32'h0);
    read_chk("rst_sticky_clear", 4'h9, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
